// File: rtl/corescore_uart_tx.sv
// -----------------------------------------------------------------------------
// corescore_uart_tx
//
// Byte-stream to UART serializer. Accepts one byte per valid/ready handshake
// and shifts it out LSB first as an 8N1 or 8N2 frame. When LAST_EOL is set,
// a byte accepted with i_tlast=1 is followed by CR (0x0D) and LF (0x0A)
// frames sent back-to-back, so every message ends a terminal line.
//
// Ports:
//   i_clk     system clock
//   i_rst     synchronous reset, active high
//   i_tdata   byte to transmit
//   i_tlast   last byte of a message
//   i_tvalid  i_tdata/i_tlast valid
//   o_tready  serializer can accept a byte (IDLE and not in reset)
//   o_busy    a frame is in progress
//   o_uart_tx serial line, idles high, driven straight from a flop
// -----------------------------------------------------------------------------
module corescore_uart_tx #(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD_RATE   = 57600,
  parameter int STOP_BITS   = 1,
  parameter int LAST_EOL    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_busy,
  output logic       o_uart_tx
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "corescore_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
    $fatal(1, "corescore_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] baud_q,     baud_d;
  logic [2:0]       bit_q,      bit_d;
  logic [7:0]       shift_q,    shift_d;
  logic             eol_pend_q, eol_pend_d;
  logic             eol_idx_q,  eol_idx_d;
  logic             tx_q,       tx_d;

  logic bit_end;
  logic accept;

  assign bit_end   = (baud_q == CNT_LAST);
  assign o_tready  = (state_q == ST_IDLE) && !i_rst;
  assign accept    = i_tvalid && o_tready;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_uart_tx = tx_q;

  // tx_d is the line level for the cycle after the edge, so the register
  // already holds the start bit in the first cycle of START.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    eol_pend_d = eol_pend_q;
    eol_idx_d  = eol_idx_q;
    tx_d       = tx_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d    = i_tdata;
          eol_pend_d = i_tlast && (LAST_EOL != 0);
          eol_idx_d  = 1'b0;
          state_d    = ST_START;
          baud_d     = '0;
          bit_d      = 3'd0;
          tx_d       = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            // shift_q[1] is the next data bit since the register shifts once per bit
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else begin
            bit_d = 3'd0;
            if (eol_pend_q) begin
              // EOL step: load CR then LF and restart the frame with no gap cycle
              state_d = ST_START;
              tx_d    = 1'b0;
              if (!eol_idx_q) begin
                shift_d   = 8'h0D;
                eol_idx_d = 1'b1;
              end else begin
                shift_d    = 8'h0A;
                eol_idx_d  = 1'b0;
                eol_pend_d = 1'b0;
              end
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      eol_pend_q <= 1'b0;
      eol_idx_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      eol_pend_q <= eol_pend_d;
      eol_idx_q  <= eol_idx_d;
      tx_q       <= tx_d;
    end
  end

  // Shift register is pure data: it is always reloaded before it is used.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

endmodule
